decode_issue_queue: RTL and testbench

- Parametrised decode-to-execute boundary that replaces the single-register ID/EX latch.
- Buffers decoded micro-ops in a small FIFO with valid/ready handshakes on both sides.
- Detects load-use hazards against the EX stage and holds the offending micro-op at the input.
- Supports pipeline flush and counts input stall cycles.

---
 rtl/decode_issue_queue.sv | 167 ++++++++++++++++
 tb/tb_decode_issue_queue.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/decode_issue_queue.sv
// Decode-to-execute issue queue: a small FIFO of decoded micro-ops with load-use hold, flush and a stall counter.
// Optional writeback operand bypass into stored entries when DECODE_WB_BYPASS_EN is defined.
module decode_issue_queue #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned CTRL_WIDTH     = 24,
  parameter int unsigned DEPTH          = 2,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CTRL_WIDTH-1:0]     in_ctrl,
  input  logic [REG_ADDR_WIDTH-1:0] in_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] in_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] in_rd,
  input  logic                      in_uses_rs1,
  input  logic                      in_uses_rs2,
  input  logic [DATA_WIDTH-1:0]     in_rd1,
  input  logic [DATA_WIDTH-1:0]     in_rd2,
  input  logic [DATA_WIDTH-1:0]     in_imm,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CTRL_WIDTH-1:0]     out_ctrl,
  output logic [REG_ADDR_WIDTH-1:0] out_rs1,
  output logic [REG_ADDR_WIDTH-1:0] out_rs2,
  output logic [REG_ADDR_WIDTH-1:0] out_rd,
  output logic [DATA_WIDTH-1:0]     out_rd1,
  output logic [DATA_WIDTH-1:0]     out_rd2,
  output logic [DATA_WIDTH-1:0]     out_imm,
  input  logic                      ex_load_valid,
  input  logic [REG_ADDR_WIDTH-1:0] ex_load_rd,
  input  logic                      wb_we,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
  input  logic [DATA_WIDTH-1:0]     wb_data,
  input  logic                      flush,
  output logic [CNT_WIDTH-1:0]      stall_cnt
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  logic [CTRL_WIDTH-1:0]     ctrl_q [DEPTH];
  logic [REG_ADDR_WIDTH-1:0] rs1_q  [DEPTH];
  logic [REG_ADDR_WIDTH-1:0] rs2_q  [DEPTH];
  logic [REG_ADDR_WIDTH-1:0] rd_q   [DEPTH];
  logic [DATA_WIDTH-1:0]     rd1_q  [DEPTH];
  logic [DATA_WIDTH-1:0]     rd2_q  [DEPTH];
  logic [DATA_WIDTH-1:0]     imm_q  [DEPTH];
  logic [DEPTH-1:0]          uses1_q, uses2_q;
  logic [PTR_W-1:0]          wr_ptr, rd_ptr;

  logic                  empty, full, hazard, push, pop;
  logic [IDX_W-1:0]      wr_idx, rd_idx;
  logic [DATA_WIDTH-1:0] push_rd1, push_rd2;
  logic [DEPTH-1:0]      byp1, byp2;

  assign wr_idx = wr_ptr[IDX_W-1:0];
  assign rd_idx = rd_ptr[IDX_W-1:0];
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_idx == rd_idx) && (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]);

  assign hazard = in_valid && ex_load_valid && (ex_load_rd != '0) &&
                  ((in_uses_rs1 && (in_rs1 == ex_load_rd)) ||
                   (in_uses_rs2 && (in_rs2 == ex_load_rd)));

  // Held low during reset; deliberately independent of out_ready.
  assign in_ready  = reset && !full && !hazard && !flush;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready && !flush;
  assign out_valid = !empty;

  assign out_ctrl = ctrl_q[rd_idx];
  assign out_rs1  = rs1_q[rd_idx];
  assign out_rs2  = rs2_q[rd_idx];
  assign out_rd   = rd_q[rd_idx];
  assign out_rd1  = rd1_q[rd_idx];
  assign out_rd2  = rd2_q[rd_idx];
  assign out_imm  = imm_q[rd_idx];

`ifdef DECODE_WB_BYPASS_EN
  logic [PTR_W-1:0] count;
  logic [IDX_W-1:0] offset;
  logic             wb_hit;
  logic             unused_bypass;

  assign count         = wr_ptr - rd_ptr;
  assign wb_hit        = wb_we && (wb_rd != '0);
  assign unused_bypass = ^offset;

  // Writeback forwarding into the incoming op and every occupied entry.
  always_comb begin
    push_rd1 = in_rd1;
    push_rd2 = in_rd2;
    byp1     = '0;
    byp2     = '0;
    offset   = '0;
    if (wb_hit && in_uses_rs1 && (in_rs1 == wb_rd)) push_rd1 = wb_data;
    if (wb_hit && in_uses_rs2 && (in_rs2 == wb_rd)) push_rd2 = wb_data;
    for (int i = 0; i < DEPTH; i++) begin
      offset = IDX_W'(i) - rd_idx;
      if (wb_hit && (PTR_W'(offset) < count)) begin
        byp1[i] = uses1_q[i] && (rs1_q[i] == wb_rd);
        byp2[i] = uses2_q[i] && (rs2_q[i] == wb_rd);
      end
    end
  end
`else
  logic unused_wb;
  assign unused_wb = ^{wb_we, wb_rd, wb_data, uses1_q, uses2_q};
  assign push_rd1  = in_rd1;
  assign push_rd2  = in_rd2;
  assign byp1      = '0;
  assign byp2      = '0;
`endif

  // Entry storage and pointers; flush dominates push, pop and bypass.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      uses1_q <= '0;
      uses2_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ctrl_q[i] <= '0;
        rs1_q[i]  <= '0;
        rs2_q[i]  <= '0;
        rd_q[i]   <= '0;
        rd1_q[i]  <= '0;
        rd2_q[i]  <= '0;
        imm_q[i]  <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (byp1[i]) rd1_q[i] <= wb_data;
        if (byp2[i]) rd2_q[i] <= wb_data;
      end
      if (push) begin
        ctrl_q[wr_idx]  <= in_ctrl;
        rs1_q[wr_idx]   <= in_rs1;
        rs2_q[wr_idx]   <= in_rs2;
        rd_q[wr_idx]    <= in_rd;
        uses1_q[wr_idx] <= in_uses_rs1;
        uses2_q[wr_idx] <= in_uses_rs2;
        rd1_q[wr_idx]   <= push_rd1;
        rd2_q[wr_idx]   <= push_rd2;
        imm_q[wr_idx]   <= in_imm;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Saturating count of cycles an offered micro-op was refused.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (in_valid && !in_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_decode_issue_queue.sv
// Directed bench for decode_issue_queue: latency, full hold, load-use hazard, flush, bypass, counter saturation.
module tb_decode_issue_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [23:0] in_ctrl;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_uses_rs1, in_uses_rs2;
  logic [31:0] in_rd1, in_rd2, in_imm;
  logic        out_valid, out_ready;
  logic [23:0] out_ctrl;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [31:0] out_rd1, out_rd2, out_imm;
  logic        ex_load_valid;
  logic [4:0]  ex_load_rd;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush;
  logic [15:0] stall_cnt;

  logic        sat_reset, sat_valid, sat_in_ready, sat_out_valid;
  logic [23:0] sat_ctrl;
  logic [4:0]  sat_rs1, sat_rs2, sat_rd;
  logic [31:0] sat_rd1, sat_rd2, sat_imm;
  logic [3:0]  sat_stall;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  decode_issue_queue u_dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_uses_rs1(in_uses_rs1), .in_uses_rs2(in_uses_rs2),
    .in_rd1(in_rd1), .in_rd2(in_rd2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_rd1(out_rd1), .out_rd2(out_rd2), .out_imm(out_imm),
    .ex_load_valid(ex_load_valid), .ex_load_rd(ex_load_rd),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush), .stall_cnt(stall_cnt)
  );

  decode_issue_queue #(.CNT_WIDTH(4)) u_sat (
    .clk(clk), .reset(sat_reset),
    .in_valid(sat_valid), .in_ready(sat_in_ready), .in_ctrl(in_ctrl),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_uses_rs1(in_uses_rs1), .in_uses_rs2(in_uses_rs2),
    .in_rd1(in_rd1), .in_rd2(in_rd2), .in_imm(in_imm),
    .out_valid(sat_out_valid), .out_ready(1'b0), .out_ctrl(sat_ctrl),
    .out_rs1(sat_rs1), .out_rs2(sat_rs2), .out_rd(sat_rd),
    .out_rd1(sat_rd1), .out_rd2(sat_rd2), .out_imm(sat_imm),
    .ex_load_valid(1'b0), .ex_load_rd(5'd0),
    .wb_we(1'b0), .wb_rd(5'd0), .wb_data(32'd0),
    .flush(1'b0), .stall_cnt(sat_stall)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic offer(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                       input logic u2, input logic [31:0] rd1);
    in_valid    = 1'b1;
    in_ctrl     = rd1[23:0];
    in_rs1      = rs1;
    in_uses_rs1 = u1;
    in_rs2      = rs2;
    in_uses_rs2 = u2;
    in_rd       = 5'd3;
    in_rd1      = rd1;
    in_rd2      = ~rd1;
    in_imm      = rd1 + 32'd1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_byp;
    reset = 1'b0; sat_reset = 1'b0; sat_valid = 1'b1;
    in_valid = 0; in_ctrl = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0;
    in_uses_rs1 = 0; in_uses_rs2 = 0; in_rd1 = 0; in_rd2 = 0; in_imm = 0;
    out_ready = 0; ex_load_valid = 0; ex_load_rd = 0;
    wb_we = 0; wb_rd = 0; wb_data = 0; flush = 0;
    tick(); #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_rd1", out_rd1, 32'd0);
    check("rst_out_ctrl", 32'(out_ctrl), 32'd0);
    check("rst_stall", 32'(stall_cnt), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    tick();
    reset = 1'b1; sat_reset = 1'b1;

    // single op, 1-cycle latency
    offer(5'd1, 1'b1, 5'd0, 1'b0, 32'h11);
    in_ctrl = 24'h00ABCD; out_ready = 1'b1;
    #1;
    check("lat_in_ready", 32'(in_ready), 32'd1);
    check("lat_no_fallthru", 32'(out_valid), 32'd0);
    tick(); in_valid = 1'b0; #1;
    check("lat_out_valid", 32'(out_valid), 32'd1);
    check("lat_out_rd1", out_rd1, 32'h11);
    check("lat_out_ctrl", 32'(out_ctrl), 32'h00ABCD);
    tick();
    check("lat_empty", 32'(out_valid), 32'd0);

    // full FIFO holds the third op
    out_ready = 1'b0;
    offer(5'd2, 1'b1, 5'd0, 1'b0, 32'hA); #1;
    check("full_a_ready", 32'(in_ready), 32'd1);
    tick(); offer(5'd2, 1'b1, 5'd0, 1'b0, 32'hB); #1;
    check("full_b_ready", 32'(in_ready), 32'd1);
    tick(); offer(5'd2, 1'b1, 5'd0, 1'b0, 32'hC); #1;
    check("full_c_ready", 32'(in_ready), 32'd0);
    check("full_head_a", out_rd1, 32'hA);
    tick();
    check("full_stall1", 32'(stall_cnt), 32'd1);
    tick();
    check("full_stall2", 32'(stall_cnt), 32'd2);
    out_ready = 1'b1; #1;
    check("full_no_ready_dep", 32'(in_ready), 32'd0);
    tick();
    check("full_stall3", 32'(stall_cnt), 32'd3);
    check("drain_b", out_rd1, 32'hB);
    check("drain_ready", 32'(in_ready), 32'd1);
    tick(); in_valid = 1'b0; #1;
    check("drain_c", out_rd1, 32'hC);
    check("drain_c_imm", out_imm, 32'hD);
    check("drain_c_rd2", out_rd2, ~32'hC);
    tick();
    check("drain_empty", 32'(out_valid), 32'd0);

    // load-use hazard
    ex_load_valid = 1'b1; ex_load_rd = 5'd5;
    offer(5'd0, 1'b0, 5'd5, 1'b1, 32'h55); #1;
    check("haz_block", 32'(in_ready), 32'd0);
    tick();
    check("haz_stall", 32'(stall_cnt), 32'd4);
    in_uses_rs2 = 1'b0; #1;
    check("haz_unused_rs2", 32'(in_ready), 32'd1);
    tick();
    in_uses_rs2 = 1'b1; ex_load_rd = 5'd0; in_rs2 = 5'd0; #1;
    check("haz_rd0", 32'(in_ready), 32'd1);
    tick(); in_valid = 1'b0; ex_load_valid = 1'b0;
    check("haz_no_stall", 32'(stall_cnt), 32'd4);
    tick();
    check("haz_empty", 32'(out_valid), 32'd0);

    // flush drops buffered and incoming ops
    out_ready = 1'b0;
    offer(5'd4, 1'b1, 5'd0, 1'b0, 32'hD0);
    tick(); offer(5'd4, 1'b1, 5'd0, 1'b0, 32'hE0);
    tick(); offer(5'd4, 1'b1, 5'd0, 1'b0, 32'hF0); flush = 1'b1; #1;
    check("fl_in_ready", 32'(in_ready), 32'd0);
    check("fl_full_before", 32'(out_valid), 32'd1);
    tick(); flush = 1'b0; in_valid = 1'b0; #1;
    check("fl_empty", 32'(out_valid), 32'd0);
    check("fl_stall", 32'(stall_cnt), 32'd5);
    tick();
    check("fl_dropped", 32'(out_valid), 32'd0);
    offer(5'd4, 1'b1, 5'd0, 1'b0, 32'h60);
    tick(); in_valid = 1'b0; #1;
    check("fl_after_push", out_rd1, 32'h60);
    out_ready = 1'b1;
    tick(); out_ready = 1'b0;

    // writeback bypass into a stored entry
    offer(5'd7, 1'b1, 5'd0, 1'b0, 32'h0);
    tick(); in_valid = 1'b0;
    wb_we = 1'b1; wb_rd = 5'd7; wb_data = 32'hDEAD_BEEF;
    tick(); wb_we = 1'b0;
`ifdef DECODE_WB_BYPASS_EN
    exp_byp = 32'hDEAD_BEEF;
`else
    exp_byp = 32'h0;
`endif
    check("byp_rd1", out_rd1, exp_byp);
    check("byp_rd2_untouched", out_rd2, 32'hFFFF_FFFF);
    out_ready = 1'b1;
    tick(); out_ready = 1'b0;

    // saturation on the 4-bit counter instance
    repeat (20) tick();
    check("sat_hold", 32'(sat_stall), 32'hF);
    tick();
    check("sat_hold2", 32'(sat_stall), 32'hF);
    #2 sat_reset = 1'b0; #1;
    check("sat_async_clr", 32'(sat_stall), 32'd0);
    check("sat_rst_ready", 32'(sat_in_ready), 32'd0);
    check("sat_rst_empty", 32'(sat_out_valid), 32'd0);
    tick(); sat_reset = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
